accum_ctrl: RTL
===============

// Module: accum_ctrl
// PURPOSE
//   Sequencer for the floating-point accumulate datapath (FP adder + accumulator register).
//   Per run it clears the accumulator and streams cfg_terms FP32 operands into it, one per cycle.
//   It then captures the final sum and presents it on a valid/ready result port.
//   Sits between the convolution window/multiplier stage (product stream) and the output writer.
// PARAMETERS
//   DATA_W  32  operand/result width (IEEE-754 single)
//   CNT_W   8   width of term counter; max terms per run = 2**CNT_W-1
// PORTS
//   clk        in   1       clock, all state updates on rising edge
//   rst        in   1       asynchronous, active-high reset
//   start      in   1       begin a run; sampled only in IDLE
//   cfg_terms  in   CNT_W   number of terms for the run; latched with start
//   busy       out  1       high in every state except IDLE
//   in_data    in   DATA_W  FP32 product/term
//   in_valid   in   1       in_data valid
//   in_ready   out  1       high only in ACCUM; term accepted when in_valid&in_ready
//   acc_b      out  DATA_W  to adder OP_B: in_data while in ACCUM, else 32'h0
//   acc_en     out  1       accumulator load enable = in_valid & in_ready
//   acc_clr    out  1       synchronous accumulator clear (priority over acc_en in accumulator)
//   acc_sum    in   DATA_W  accumulator register output
//   res_data   out  DATA_W  captured run result
//   res_valid  out  1       result valid; held until res_ready
//   res_ready  in   1       downstream accepts result
// BEHAVIOUR
//   States: IDLE, CLEAR, ACCUM, WAIT, OUT. Registered state, remaining-count, res_data.
//   Reset (async, any state): state=IDLE, remaining=0, res_data=0; all outputs 0.
//   IDLE : start=1 -> latch remaining=cfg_terms, go CLEAR. start=0 -> stay.
//   CLEAR: acc_clr=1 for exactly this cycle. remaining!=0 -> ACCUM; remaining==0 -> WAIT.
//   ACCUM: in_ready=1, acc_b=in_data, acc_en=in_valid.
//          Per accepted term: remaining-=1.
//          Term accepted with remaining==1 -> WAIT. in_valid=0: hold (stall), no count change.
//   WAIT : one cycle; accumulator now holds final sum; res_data<=acc_sum at end of cycle -> OUT.
//          For cfg_terms==0, acc_sum is the cleared value, so res_data=32'h0.
//   OUT  : res_valid=1, res_data stable. res_ready=1 -> IDLE; else hold indefinitely.
//   Latency (start at cycle 0, in_valid held high, N>=1 terms):
//     CLEAR @1; terms accepted @2..N+1; WAIT @N+2; res_valid from cycle N+3.
//   Throughput: one term/cycle; next start accepted the cycle after the result handshake.
//   start outside IDLE is ignored; cfg_terms is only sampled with an accepted start.
//   acc_en and in_ready are never high outside ACCUM; acc_clr is never high outside CLEAR.
//   No term is accepted in the cycle the count reaches 0.
//   Surplus in_valid after the last term is left unaccepted for the next run.
//   rst mid-run: abort run with no partial result.
//     The accumulator reset clears the sum; the next run starts from CLEAR regardless.
//   The controller does no FP arithmetic; sum correctness is set by the adder, order = arrival.
// TESTING
//   1) cfg_terms=3; 3F800000,40000000,40400000 with in_valid high
//      -> res_data=40C00000; res_valid rises at cycle 6 after start.
//   2) Same terms, in_valid low 2 cycles between terms
//      -> same 40C00000; acc_en high exactly 3 cycles; busy high throughout.
//   3) cfg_terms=0 -> acc_clr pulse, acc_en never high; res_data=00000000 at cycle 3.
//   4) res_ready low 5 cycles in OUT, start pulsed meanwhile
//      -> res_valid/res_data stable, start ignored; IDLE after res_ready.
//   5) rst after 2 of 4 terms -> all outputs 0 next cycle;
//      new run 3F800000+3F800000 -> 40000000.
//   6) Back-to-back runs {3F800000} then {40000000}, start right after handshake
//      -> second result 40000000 (not 40400000): clear verified.

Source files
------------

// File: rtl/accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | accum_ctrl: sequencer for the FP accumulate datapath (clear, stream, emit) |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module accum_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_terms,
  output logic              busy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] acc_b,
  output logic              acc_en,
  output logic              acc_clr,
  input  logic [DATA_W-1:0] acc_sum,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLEAR = 3'd1;
  localparam logic [2:0] c_ACCUM = 3'd2;
  localparam logic [2:0] c_WAIT  = 3'd3;
  localparam logic [2:0] c_OUT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    res_data_d  = res_data_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          remaining_d = cfg_terms;
          state_d     = c_CLEAR;
        end
      end
      c_CLEAR: begin
        state_d = (remaining_q != '0) ? c_ACCUM : c_WAIT;
      end
      c_ACCUM: begin
        if (in_valid) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = c_WAIT;
          end
        end
      end
      c_WAIT: begin
        // The last accepted term has landed in the accumulator by now.
        res_data_d = acc_sum;
        state_d    = c_OUT;
      end
      c_OUT: begin
        if (res_ready) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_IDLE;
      remaining_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = (state_q != c_IDLE);
  assign in_ready  = (state_q == c_ACCUM);
  assign acc_en    = in_valid & in_ready;
  assign acc_b     = in_ready ? in_data : '0;
  assign acc_clr   = (state_q == c_CLEAR);
  assign res_valid = (state_q == c_OUT);
  assign res_data  = res_data_q;

endmodule
`default_nettype wire
